// File: rtl/dram_arbiter_pkg.sv
// Shared types and helpers for the DRAM request arbiter: tag layout,
// arbitration mode constants and the rotating find-first search.
package dram_arbiter_pkg;

  localparam int ARB_RR    = 0;
  localparam int ARB_FIXED = 1;

  localparam int TAG_CH_W   = 3;
  localparam int TAG_ADDR_W = 64;
  localparam int TAG_META_W = 64;

  // Fields sized for the widest supported configuration; unused upper bits stay zero.
  typedef struct packed {
    logic [TAG_CH_W-1:0]   ch;
    logic                  we;
    logic [TAG_ADDR_W-1:0] addr;
    logic [TAG_META_W-1:0] meta;
  } tag_t;

  // Returns {found, index} of the first set bit at or after start, wrapping at n.
  function automatic logic [3:0] find_first_rr(input logic [7:0] elig,
                                               input logic [2:0] start,
                                               input int n);
    logic [3:0] res;
    int idx;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= n) idx = idx - n;
      if (k < n && elig[idx[2:0]]) res = {1'b1, idx[2:0]};
    end
    return res;
  endfunction

endpackage

// File: rtl/dram_tag_fifo.sv
// In-order tag FIFO: first-word fall-through read, registered full/empty
// derived from the occupancy counter.
module dram_tag_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A pop while full does not free a slot for a same-cycle push.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dram_arbiter.sv
// Multi-channel arbiter in front of the UberDDR3 user port: credit-gated
// grant, in-order tag tracking and read-completion routing.
module dram_arbiter
  import dram_arbiter_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 128,
  parameter int META_W      = 16,
  parameter int TAG_DEPTH   = 64,
  parameter int RSP_CREDITS = 16,
  parameter int ARB_MODE    = 0
) (
  input  logic                        clk_dram_ctrl,
  input  logic                        rst_dram_ctrl_n,
  input  logic [NUM_CH-1:0]           req_valid,
  output logic [NUM_CH-1:0]           req_ready,
  input  logic [NUM_CH-1:0]           req_we,
  input  logic [NUM_CH*ADDR_W-1:0]    req_addr,
  input  logic [NUM_CH*DATA_W-1:0]    req_wdata,
  input  logic [NUM_CH*META_W-1:0]    req_meta,
  output logic [NUM_CH-1:0]           rsp_valid,
  output logic [DATA_W-1:0]           rsp_data,
  output logic [ADDR_W-1:0]           rsp_addr,
  output logic [META_W-1:0]           rsp_meta,
  input  logic [NUM_CH-1:0]           rsp_credit_return,
  output logic [ADDR_W-1:0]           memrequest_addr,
  output logic                        memrequest_en,
  output logic [DATA_W-1:0]           memrequest_write_data,
  output logic                        memrequest_write_enable,
  input  logic [DATA_W-1:0]           memrequest_resp_data,
  input  logic                        memrequest_complete,
  input  logic                        memrequest_busy,
  output logic [$clog2(TAG_DEPTH):0]  outstanding,
  output logic                        idle
);

  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int TAG_W = CH_W + 1 + ADDR_W + META_W;
  localparam logic [7:0] CREDIT_MAX = 8'(RSP_CREDITS);

  logic [7:0]        credit      [NUM_CH];
  logic [7:0]        credit_next [NUM_CH];
  logic [NUM_CH-1:0] elig;
  logic [NUM_CH-1:0] rd_take;
  logic [NUM_CH-1:0] overflow;
  logic [CH_W-1:0]   rr;
  logic [3:0]        pick;
  logic [CH_W-1:0]   grant;
  logic              issue;
  logic              complete;
  logic              fifo_full;
  logic              fifo_empty;
  logic [TAG_W-1:0]  push_tag;
  logic [TAG_W-1:0]  head_raw;
  tag_t              head;
  logic              unused_head;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      elig[i] = req_valid[i] && (req_we[i] || credit[i] != '0);
    end
  end

  assign pick  = find_first_rr(8'(elig), (ARB_MODE == ARB_FIXED) ? 3'd0 : 3'(rr), NUM_CH);
  assign grant = CH_W'(pick[2:0]);

  // Outputs are held quiet while reset is asserted even though state is already cleared.
  assign issue         = rst_dram_ctrl_n && pick[3] && !memrequest_busy && !fifo_full;
  assign memrequest_en = issue;
  assign req_ready     = issue ? (NUM_CH'(1) << grant) : '0;

  assign memrequest_addr         = req_addr[grant*ADDR_W +: ADDR_W];
  assign memrequest_write_data   = req_wdata[grant*DATA_W +: DATA_W];
  assign memrequest_write_enable = req_we[grant];

  assign push_tag = {grant, req_we[grant], req_addr[grant*ADDR_W +: ADDR_W],
                     req_meta[grant*META_W +: META_W]};
  assign complete = memrequest_complete && !fifo_empty;

  dram_tag_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk   (clk_dram_ctrl),
    .rst_n (rst_dram_ctrl_n),
    .push  (issue),
    .din   (push_tag),
    .pop   (complete),
    .dout  (head_raw),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (outstanding)
  );

  always_comb begin
    head = '0;
    head.meta[META_W-1:0] = head_raw[META_W-1:0];
    head.addr[ADDR_W-1:0] = head_raw[META_W +: ADDR_W];
    head.we               = head_raw[META_W + ADDR_W];
    head.ch[CH_W-1:0]     = head_raw[META_W + ADDR_W + 1 +: CH_W];
  end
  assign unused_head = ^head;

  assign rsp_valid = (rst_dram_ctrl_n && complete && !head.we) ? (NUM_CH'(1) << head.ch) : '0;
  assign rsp_data  = memrequest_resp_data;
  assign rsp_addr  = head.addr[ADDR_W-1:0];
  assign rsp_meta  = head.meta[META_W-1:0];
  assign idle      = (outstanding == '0) && (req_valid == '0);

  // A same-cycle read issue and credit return cancel; returns beyond the cap are dropped.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      rd_take[i]     = issue && !req_we[i] && (grant == CH_W'(i));
      credit_next[i] = credit[i];
      overflow[i]    = 1'b0;
      if (rsp_credit_return[i] && !rd_take[i]) begin
        if (credit[i] < CREDIT_MAX) credit_next[i] = credit[i] + 8'd1;
        else                        overflow[i]    = 1'b1;
      end else if (rd_take[i] && !rsp_credit_return[i]) begin
        credit_next[i] = credit[i] - 8'd1;
      end
    end
  end

  always_ff @(posedge clk_dram_ctrl or negedge rst_dram_ctrl_n) begin
    if (!rst_dram_ctrl_n) begin
      rr <= '0;
      for (int i = 0; i < NUM_CH; i++) credit[i] <= CREDIT_MAX;
    end else begin
      if (issue) rr <= (grant == CH_W'(NUM_CH - 1)) ? '0 : grant + 1'b1;
      for (int i = 0; i < NUM_CH; i++) credit[i] <= credit_next[i];
    end
  end

  a_complete_not_empty: assert property (@(posedge clk_dram_ctrl) disable iff (!rst_dram_ctrl_n)
    memrequest_complete |-> !fifo_empty);
  a_credit_no_overflow: assert property (@(posedge clk_dram_ctrl) disable iff (!rst_dram_ctrl_n)
    overflow == '0);

endmodule
